tt_ternary_mvm_stream: RTL
==========================

Name: tt_ternary_mvm_stream

Overview:
Streaming ternary matrix-vector multiplier. It holds a resident IN_LEN x OUT_LEN ternary weight matrix loaded over a valid/ready port. It accepts an input vector LANES elements per beat, accumulates all OUT_LEN dot products in parallel, then drains saturated results one per beat. It adds several things the previous generation lacked: handshakes, parametrised lanes, wide accumulators, saturation, and optional ReLU.

Parameters:
IN_LEN, 16, input vector length; must be a multiple of LANES
OUT_LEN, 8, output vector length
BIT_WIDTH, 8, signed width of input and output elements
LANES, 2, input elements consumed per beat
ACC_WIDTH, 13, signed accumulator width; must be >= BIT_WIDTH+clog2(IN_LEN)+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state
w_valid  in  1  weight row valid
w_ready  out  1  weight row accepted when high with w_valid
w_data  in  2*OUT_LEN  ternary weights of input index w_ptr; bits [2o+1:2o] are for output o
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when high with in_valid
in_data  in  LANES*BIT_WIDTH  signed elements; lane 0 in LSBs is the lowest input index
relu_en  in  1  ReLU mode; sampled on the first input beat
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  BIT_WIDTH  saturated (optionally ReLU'd) result
out_idx  out  clog2(OUT_LEN)  output index of out_data
out_last  out  1  high with out_idx==OUT_LEN-1
out_sat  out  1  out_data was clipped by saturation
busy  out  1  state != IDLE

Behaviour:
- Weight encoding: 01 = +1, 11 = -1, 00 and 10 = 0.
- Reset (async, rst_n low): state IDLE; all weights, w_ptr, accumulators, beat counter, drain index and relu latch cleared to 0. Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, busy=0. w_ready and in_ready are 0 while rst_n is low.
- en low: no state changes; w_ready, in_ready and out_valid are forced to 0; out_data and out_idx hold.
- IDLE:
  - w_ready = en.
  - in_ready = en & !w_valid, so a weight write wins a simultaneous request.
  - Weight handshake writes w_data to row w_ptr; w_ptr increments and wraps IN_LEN-1 -> 0.
  - Weights persist across vectors.
- IDLE, first input handshake: latch relu_en; acc[o] = beat sum; beat counter = 1; go to ACCUM. If IN_LEN==LANES, go directly to DRAIN.
- ACCUM:
  - w_ready = 0; in_ready = en.
  - Each accepted beat k adds to acc[o] the sum over lanes l of t(W[k*LANES+l][o]) * x_l.
  - Every term is sign-extended to ACC_WIDTH before any negation, so -(-128) = +128 is exact.
  - After beat IN_LEN/LANES-1, go to DRAIN.
- DRAIN:
  - in_ready = 0; w_ready = 0; out_valid = en.
  - out_data = sat(acc[out_idx]) clipped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]. If relu is latched, negative values become 0.
  - out_sat = 1 only when clipping occurred; it is 0 when ReLU zeroes a value.
  - On handshake, out_idx increments. The handshake at out_idx=OUT_LEN-1 returns to IDLE and resets out_idx to 0.
  - out_data, out_idx and out_sat stay stable while out_valid & !out_ready.
- Latency: out_valid rises the cycle after the final input beat is accepted. Minimum period per vector is IN_LEN/LANES + OUT_LEN cycles.
- Reset mid-operation aborts immediately. There is no partial output, and the weights must be reloaded.

Decomposition:
- Package tt_ternary_pkg:
  - weight codes W_ZERO, W_POS, W_NEG
  - state typedef (IDLE, ACCUM, DRAIN)
  - saturate and ternary-product helper functions
- Sub-module tt_ternary_lane_mac: one output column. It contains the LANES-input ternary adder tree and the ACC_WIDTH accumulator register with clear-on-first-beat. The top instantiates OUT_LEN copies.

Test Plan:
1. Reset; 16 weight writes of all 01; 8 beats of x=1, relu_en=0 -> out_idx 0..7 each out_data=16, out_last on idx 7, out_sat=0, then busy=0.
2. Weights +1 for even inputs and -1 for odd inputs, x_i=i: relu_en=0 -> every output -8 (0xF8); relu_en=1 -> every output 0 with out_sat=0.
3. Saturation, all inputs -128:
   - all weights 11 -> acc=+2048, out_data=127, out_sat=1
   - all weights 01 -> acc=-2048, out_data=-128 (0x80), out_sat=1
4. Backpressure: hold out_ready low 3 cycles at out_idx=2 -> out_data/out_idx/out_sat stable; in_valid during DRAIN is not accepted (in_ready=0).
5. Priority and enable:
   - w_valid and in_valid together in IDLE -> weight written, in_ready=0, w_ptr advances.
   - en low for 5 cycles mid-ACCUM -> results identical to scenario 1.
6. Assert rst_n low mid-DRAIN -> out_valid=0 at once; after release, a vector of x=5 yields all outputs 0 (weights cleared).

Source files
------------

// File: rtl/tt_ternary_pkg.sv
// Shared types and arithmetic helpers for the ternary matrix-vector streamer.
package tt_ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  // Wide signed carrier so helpers work for any ACC_WIDTH/BIT_WIDTH up to 64.
  typedef logic signed [63:0] wide_t;

  // Ternary product; x arrives already sign-extended, so -(-2^(n-1)) is exact.
  function automatic wide_t tern_prod(input logic [1:0] w, input wide_t x);
    case (w)
      W_POS:   return x;
      W_NEG:   return -x;
      default: return '0;
    endcase
  endfunction

  function automatic wide_t sat_clip(input wide_t v, input int bw);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (bw - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input wide_t v, input int bw);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (bw - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/tt_ternary_lane_mac.sv
// One output column: LANES-wide ternary adder tree feeding a wide accumulator.
module tt_ternary_lane_mac import tt_ternary_pkg::*; #(
  parameter int LANES     = 2,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 13
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              beat,
  input  logic                              first,
  input  logic [LANES-1:0][1:0]             w,
  input  logic [LANES-1:0][BIT_WIDTH-1:0]   x,
  output logic [ACC_WIDTH-1:0]              acc
);

  logic [ACC_WIDTH-1:0] beat_sum;

  // Sum of the lane products for the current beat.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum = beat_sum + ACC_WIDTH'(tern_prod(w[l], wide_t'($signed(x[l]))));
  end

  // First beat of a vector overwrites, later beats accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (beat) acc <= first ? beat_sum : acc + beat_sum;
  end

endmodule

// File: rtl/tt_ternary_mvm_stream.sv
// Streaming ternary MVM: resident weights, LANES inputs per beat, serial drain.
module tt_ternary_mvm_stream import tt_ternary_pkg::*; #(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 8,
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 2,
  parameter int ACC_WIDTH = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [2*OUT_LEN-1:0]          w_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*BIT_WIDTH-1:0]    in_data,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_WIDTH-1:0]          out_data,
  output logic [$clog2(OUT_LEN)-1:0]    out_idx,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int NBEATS = IN_LEN / LANES;
  localparam int IW     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int BCW    = $clog2(NBEATS + 1);
  localparam int OW     = $clog2(OUT_LEN);

  state_t                            state, state_nxt;
  logic [IN_LEN-1:0][2*OUT_LEN-1:0]  wmem;
  logic [IW-1:0]                     w_ptr;
  logic [BCW-1:0]                    beat_cnt, beat_idx;
  logic                              relu_q;
  logic [OUT_LEN-1:0][ACC_WIDTH-1:0] acc;
  logic [LANES-1:0][IW-1:0]          row;
  logic                              w_fire, in_fire, out_fire;
  logic                              first_beat, last_beat, last_out;
  logic signed [ACC_WIDTH-1:0]       sel;

  assign w_ready    = rst_n & en & (state == IDLE);
  assign in_ready   = rst_n & en & (((state == IDLE) & ~w_valid) | (state == ACCUM));
  assign out_valid  = en & (state == DRAIN);
  assign w_fire     = w_valid & w_ready;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign first_beat = (state == IDLE);
  assign beat_idx   = first_beat ? '0 : beat_cnt;
  assign last_beat  = (beat_idx == BCW'(NBEATS - 1));
  assign last_out   = (out_idx == OW'(OUT_LEN - 1));
  assign busy       = (state != IDLE);

  // Weight row addressed by each lane for the beat being accepted.
  always_comb begin
    for (int l = 0; l < LANES; l++)
      row[l] = IW'(int'(beat_idx) * LANES + l);
  end

  for (genvar o = 0; o < OUT_LEN; o++) begin : g_col
    logic [LANES-1:0][1:0] wcol;
    // Slice this column's 2-bit codes out of the selected rows.
    always_comb begin
      for (int l = 0; l < LANES; l++)
        wcol[l] = wmem[row[l]][2*o +: 2];
    end
    tt_ternary_lane_mac #(
      .LANES(LANES), .BIT_WIDTH(BIT_WIDTH), .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
      .clk(clk), .rst_n(rst_n), .beat(in_fire), .first(first_beat),
      .w(wcol), .x(in_data), .acc(acc[o])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; last_beat also covers the single-beat (IN_LEN==LANES) case.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = last_beat ? DRAIN : ACCUM;
      ACCUM:   if (in_fire && last_beat) state_nxt = DRAIN;
      DRAIN:   if (out_fire && last_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight store, beat counter, ReLU latch and drain index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmem     <= '0;
      w_ptr    <= '0;
      beat_cnt <= '0;
      relu_q   <= 1'b0;
      out_idx  <= '0;
    end else begin
      if (w_fire) begin
        wmem[w_ptr] <= w_data;
        w_ptr       <= (w_ptr == IW'(IN_LEN - 1)) ? '0 : w_ptr + 1'b1;
      end
      if (in_fire) begin
        beat_cnt <= beat_idx + 1'b1;
        if (first_beat) relu_q <= relu_en;
      end
      if (out_fire) out_idx <= last_out ? '0 : out_idx + 1'b1;
    end
  end

  assign sel = $signed(acc[out_idx]);

  // Result formatting; ReLU zeroing is not reported as saturation.
  always_comb begin
    out_data = '0;
    out_sat  = 1'b0;
    out_last = 1'b0;
    if (state == DRAIN) begin
      out_last = last_out;
      if (!(relu_q && sel < 0)) begin
        out_data = BIT_WIDTH'(sat_clip(wide_t'(sel), BIT_WIDTH));
        out_sat  = sat_hit(wide_t'(sel), BIT_WIDTH);
      end
    end
  end

endmodule
